// File: rtl/traffic_phase_sched_if.sv
// Signal bundle between the intersection phase scheduler and its surroundings.
// Combinational wires only. The bundle adds no cycles of latency.
// There is no handshake. Requests are levels or pulses, and the heads are driven every cycle.
interface traffic_phase_sched_if;
   logic       car_sense;
   logic       ped_req;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic       walk;
   logic [2:0] phase;

   // Scheduler side
   modport slave (
      input  car_sense,
      input  ped_req,
      output hwy,
      output cntry,
      output walk,
      output phase
   );

   // Sensor / environment side
   modport master (
      output car_sense,
      output ped_req,
      input  hwy,
      input  cntry,
      input  walk,
      input  phase
   );
endinterface

// File: rtl/traffic_phase_sched.sv
// Timed phase scheduler for the highway/country intersection, with latched car/ped requests.
// The phase and walk registers update on each rising clk edge. The heads are decoded combinationally from phase.
// There is no backpressure. Requests are latched until served, and the highway yields only after its minimum green.
module traffic_phase_sched #(
   parameter int CNT_W     = 8,
   parameter int HWY_MIN_G = 20,
   parameter int CNTRY_G   = 15,
   parameter int YEL_T     = 4,
   parameter int ALLRED_T  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   traffic_phase_sched_if.slave bus
);

   typedef enum logic [2:0] {
      HG  = 3'd0,
      HY  = 3'd1,
      AR1 = 3'd2,
      CG  = 3'd3,
      CY  = 3'd4,
      AR2 = 3'd5
   } phase_t;

   localparam logic [CNT_W-1:0] T_HG  = CNT_W'(HWY_MIN_G - 1);
   localparam logic [CNT_W-1:0] T_CG  = CNT_W'(CNTRY_G - 1);
   localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YEL_T - 1);
   localparam logic [CNT_W-1:0] T_AR  = CNT_W'(ALLRED_T - 1);

   localparam logic [1:0] RED = 2'b00;
   localparam logic [1:0] YEL = 2'b01;
   localparam logic [1:0] GRN = 2'b10;

   phase_t           phase;
   logic [CNT_W-1:0] timer;
   logic             car_pend;
   logic             ped_pend;
   logic             ped_srv;
   logic             walk;
   logic             tmo;

   assign tmo = (timer == '0);

   // Phase sequencing, dwell timer, request latches and the walk lamp
   always_ff @(posedge clk) begin
      if (rst) begin
         phase    <= HG;
         timer    <= T_HG;
         car_pend <= 1'b0;
         ped_pend <= 1'b0;
         ped_srv  <= 1'b0;
         walk     <= 1'b0;
      end else begin
         // Requests latch by default. Entry into CG overrides this below, because the later assignment wins.
         if (bus.car_sense && phase != CG) car_pend <= 1'b1;
         if (bus.ped_req)                  ped_pend <= 1'b1;

         case (phase)
            HG: begin
               // The timer parks at zero until someone is waiting on the country side
               if (!tmo) begin
                  timer <= timer - 1'b1;
               end else if (car_pend || ped_pend) begin
                  phase <= HY;
                  timer <= T_YEL;
               end
            end
            HY: begin
               if (tmo) begin
                  phase <= AR1;
                  timer <= T_AR;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            AR1: begin
               if (tmo) begin
                  // Serve everything pending now, including a button press that arrives on this edge
                  phase    <= CG;
                  timer    <= T_CG;
                  car_pend <= 1'b0;
                  ped_pend <= 1'b0;
                  ped_srv  <= ped_pend | bus.ped_req;
                  walk     <= ped_pend | bus.ped_req;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            CG: begin
               if (tmo) begin
                  phase   <= CY;
                  timer   <= T_YEL;
                  ped_srv <= 1'b0;
                  walk    <= 1'b0;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            CY: begin
               if (tmo) begin
                  phase <= AR2;
                  timer <= T_AR;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            AR2: begin
               if (tmo) begin
                  phase <= HG;
                  timer <= T_HG;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: begin
               // Unused codes recover to highway green with a fresh minimum green
               phase   <= HG;
               timer   <= T_HG;
               ped_srv <= 1'b0;
               walk    <= 1'b0;
            end
         endcase
      end
   end

   // Head decode from the phase register alone, so both heads are never non-RED together
   always_comb begin
      bus.hwy   = RED;
      bus.cntry = RED;
      case (phase)
         HG:      bus.hwy   = GRN;
         HY:      bus.hwy   = YEL;
         CG:      bus.cntry = GRN;
         CY:      bus.cntry = YEL;
         default: begin
            bus.hwy   = RED;
            bus.cntry = RED;
         end
      endcase
   end

   assign bus.phase = phase;
   assign bus.walk  = walk;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Self-checking bench for traffic_phase_sched. It runs directed scenarios followed by randomized requests.
// The outputs are sampled 1 time unit after each rising edge and compared against a cycle-count model.
// The design has no backpressure. The inputs are driven between edges.
module tb_traffic_phase_sched;

   localparam int HWY_MIN_G = 20;
   localparam int CNTRY_G   = 15;
   localparam int YEL_T     = 4;
   localparam int ALLRED_T  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   traffic_phase_sched_if bus ();

   traffic_phase_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   int walk_hi    = 0;

   // Reference model. It tracks the phase index and the number of cycles already spent in that phase.
   int m_ph = 0;
   int m_el = 0;
   bit m_car = 0, m_ped = 0, m_srv = 0, m_walk = 0;

   function automatic int dur(input int p);
      case (p)
         0:       return HWY_MIN_G;
         1, 4:    return YEL_T;
         3:       return CNTRY_G;
         default: return ALLRED_T;
      endcase
   endfunction

   task automatic model_edge(input bit car, input bit ped, input bit r);
      bit done;
      bit n_car, n_ped;
      if (r) begin
         m_ph = 0; m_el = 0; m_car = 0; m_ped = 0; m_srv = 0; m_walk = 0;
         return;
      end
      done  = (m_el >= dur(m_ph) - 1);
      n_car = m_car | (car && m_ph != 3);
      n_ped = m_ped | ped;
      if (m_ph == 0) begin
         if (done && (m_car || m_ped)) begin
            m_ph = 1; m_el = 0;
         end else if (!done) begin
            m_el++;
         end
      end else if (done) begin
         if (m_ph == 2) begin
            m_srv  = m_ped | ped;
            m_walk = m_srv;
            n_ped  = 0;
            n_car  = 0;
         end
         if (m_ph == 3) begin
            m_srv  = 0;
            m_walk = 0;
         end
         m_ph = (m_ph + 1) % 6;
         m_el = 0;
      end else begin
         m_el++;
      end
      m_car = n_car;
      m_ped = n_ped;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive the inputs, clock the DUT and the model, then compare the outputs
   task automatic step(input bit car, input bit ped, input bit r);
      bus.car_sense = car;
      bus.ped_req   = ped;
      rst           = r;
      @(posedge clk);
      model_edge(car, ped, r);
      #1;
      chk("phase", 8'(bus.phase), 8'(m_ph));
      chk("hwy",   8'(bus.hwy),   8'(m_ph == 0 ? 2 : (m_ph == 1 ? 1 : 0)));
      chk("cntry", 8'(bus.cntry), 8'(m_ph == 3 ? 2 : (m_ph == 4 ? 1 : 0)));
      chk("walk",  8'(bus.walk),  8'(m_walk));
      if (bus.walk === 1'b1) walk_hi++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   // Advance with no requests until the model reaches the given phase and elapsed cycle count, within a cycle budget
   task automatic run_until(input int ph, input int el, input int limit);
      int found = 0;
      for (int i = 0; i < limit && found == 0; i++) begin
         if (m_ph == ph && m_el == el) found = 1;
         else step(0, 0, 0);
      end
      chk("reach_point", 8'(found), 8'd1);
   endtask

   initial begin
      bus.car_sense = 1'b0;
      bus.ped_req   = 1'b0;

      // 1: reset for two cycles, then stay idle
      step(0, 0, 1);
      step(0, 0, 1);
      idle(100);

      // 2: single car pulse at cycle 3, one full cycle, no walk
      step(0, 0, 1);
      walk_hi = 0;
      idle(2);
      step(1, 0, 0);
      idle(60);
      chk("walk_len_car_only", 8'(walk_hi), 8'd0);

      // 3: car held high after HG has timed out, spanning a full cycle and a second one
      step(0, 0, 1);
      idle(39);
      for (int i = 0; i < 90; i++) step(1, 0, 0);
      idle(40);

      // 4: pedestrian pulse only; walk lit for exactly the country green
      step(0, 0, 1);
      walk_hi = 0;
      idle(4);
      step(0, 1, 0);
      idle(60);
      chk("walk_len_ped", 8'(walk_hi), 8'(CNTRY_G));

      // 5: button on the AR1->CG edge and again mid-CG; second country cycle follows
      step(0, 0, 1);
      step(1, 0, 0);
      run_until(2, ALLRED_T - 1, 200);
      step(0, 1, 0);
      chk("walk_on_entry_press", 8'(bus.walk), 8'd1);
      idle(6);
      step(0, 1, 0);
      walk_hi = 0;
      idle(110);
      chk("walk_len_second_cycle", 8'(walk_hi), 8'(CNTRY_G - 7 - 1 + CNTRY_G));

      // 6: reset at the 7th cycle of CG while walk is lit
      step(0, 0, 1);
      step(0, 1, 0);
      run_until(3, 6, 200);
      chk("walk_before_reset", 8'(bus.walk), 8'd1);
      step(0, 0, 1);
      idle(HWY_MIN_G + 5);

      // Randomized requests, with an occasional reset
      step(0, 0, 1);
      for (int i = 0; i < 4000; i++)
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 599) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
